// File: rtl/voice_alloc_pkg.sv
// Shared types for the voice allocator: event op codes, FSM states and the per-voice tag layout.
package voice_alloc_pkg;

  localparam int CH_W       = 4;
  localparam int NOTE_W     = 7;
  localparam int VEL_W      = 7;
  localparam int ADDR_OUT_W = 8;

  typedef enum logic [1:0] {
    OP_NOTE_ON  = 2'd0,
    OP_NOTE_OFF = 2'd1,
    OP_KEYPRESS = 2'd2,
    OP_PITCH    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef struct packed {
    logic              busy;
    logic              rel;
    logic [CH_W-1:0]   ch;
    logic [NOTE_W-1:0] note;
  } tag_t;

  // A busy voice playing the given channel/note, regardless of release state.
  function automatic logic tag_match(tag_t t, logic [CH_W-1:0] ch, logic [NOTE_W-1:0] note);
    return t.busy && (t.ch == ch) && (t.note == note);
  endfunction

endpackage

// File: rtl/voice_alloc_tag_file.sv
// Per-voice tag storage: one combinational read port for scan/issue, one busy probe for frees,
// one write port and one clear port (the write wins when both hit the same slot).
module voice_tag_file
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 256,
  parameter int AW         = $clog2(NUM_VOICES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] rd_idx_i,
  output tag_t          rd_tag_o,
  input  logic [AW-1:0] fr_idx_i,
  output logic          fr_busy_o,
  input  logic          we_i,
  input  logic [AW-1:0] widx_i,
  input  tag_t          wdata_i,
  input  logic          clr_i,
  input  logic [AW-1:0] cidx_i
);

  tag_t tags_q [NUM_VOICES];

  assign rd_tag_o  = tags_q[rd_idx_i];
  assign fr_busy_o = tags_q[fr_idx_i].busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        tags_q[i] <= '0;
      end
    end else begin
      if (clr_i) begin
        tags_q[cidx_i].busy <= 1'b0;
        tags_q[cidx_i].rel  <= 1'b0;
      end
      // Later assignment takes precedence over the clear above.
      if (we_i) begin
        tags_q[widx_i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Voice allocator in front of synth2: scans the tag file once per event, picks a slot
// (match, free, releasing, or round-robin steal) and issues registered pulses to synth2.
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 256,
  parameter int AW         = $clog2(NUM_VOICES)
) (
  input  logic                  clk96,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [CH_W-1:0]       in_channel,
  input  logic [NOTE_W-1:0]     in_note,
  input  logic [VEL_W-1:0]      in_velocity,
  input  logic                  free_valid,
  input  logic [AW-1:0]         free_addr,
  output logic                  note_pressed,
  output logic                  note_released,
  output logic                  note_keypress,
  output logic                  pitch_wheel,
  output logic [NOTE_W-1:0]     note,
  output logic [VEL_W-1:0]      velocity,
  output logic [CH_W-1:0]       channel,
  output logic [ADDR_OUT_W-1:0] addr,
  output logic [AW:0]           busy_count,
  output logic                  miss,
  output logic                  stole
);

  state_e state_q, state_d;
  logic [AW-1:0] scan_q, scan_d;
  op_e op_q, op_d;
  logic [CH_W-1:0] ev_ch_q, ev_ch_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic [VEL_W-1:0] ev_vel_q, ev_vel_d;

  logic on_vld_q, on_vld_d, act_vld_q, act_vld_d, fre_vld_q, fre_vld_d, rel_vld_q, rel_vld_d;
  logic [AW-1:0] on_idx_q, on_idx_d, act_idx_q, act_idx_d, fre_idx_q, fre_idx_d, rel_idx_q, rel_idx_d;
  logic [AW-1:0] steal_q, steal_d;
  logic [AW:0] busy_cnt_q, busy_cnt_d;

  logic pressed_q, pressed_d, released_q, released_d, keypress_q, keypress_d, pitch_q, pitch_d;
  logic miss_q, miss_d, stole_q, stole_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [ADDR_OUT_W-1:0] addr_q, addr_d;

  logic [AW-1:0] rd_idx, iss_slot;
  tag_t rd_tag, wr_tag;
  logic fr_busy, we, iss_steal, free_hit, act_ok, inc, dec, hit;
  op_e in_op_eff;

  voice_tag_file #(.NUM_VOICES(NUM_VOICES), .AW(AW)) u_tags (
    .clk_i    (clk96),
    .rst_i    (rst),
    .rd_idx_i (rd_idx),
    .rd_tag_o (rd_tag),
    .fr_idx_i (free_addr),
    .fr_busy_o(fr_busy),
    .we_i     (we),
    .widx_i   (iss_slot),
    .wdata_i  (wr_tag),
    .clr_i    (free_valid),
    .cidx_i   (free_addr)
  );

  // Slot chosen at ISSUE depends only on registered candidates, so it can address the read port.
  always_comb begin
    iss_slot  = act_idx_q;
    iss_steal = 1'b0;
    if (op_q == OP_NOTE_ON) begin
      if (on_vld_q)       iss_slot = on_idx_q;
      else if (fre_vld_q) iss_slot = fre_idx_q;
      else if (rel_vld_q) iss_slot = rel_idx_q;
      else begin
        iss_slot  = steal_q;
        iss_steal = 1'b1;
      end
    end
  end

  assign rd_idx   = (state_q == ST_ISSUE) ? iss_slot : scan_q;
  assign free_hit = free_valid && (free_addr == iss_slot);
  // A matched voice freed after it was scanned (or right now) no longer counts as a match.
  assign act_ok   = act_vld_q && rd_tag.busy && !free_hit;
  assign hit      = tag_match(rd_tag, ev_ch_q, ev_note_q);

  always_comb begin
    in_op_eff = op_e'(in_op);
    if (in_op_eff == OP_NOTE_ON && in_velocity == '0) in_op_eff = OP_NOTE_OFF;
  end

  always_comb begin
    state_d = state_q;     scan_d = scan_q;       op_d = op_q;
    ev_ch_d = ev_ch_q;     ev_note_d = ev_note_q; ev_vel_d = ev_vel_q;
    on_vld_d = on_vld_q;   act_vld_d = act_vld_q; fre_vld_d = fre_vld_q; rel_vld_d = rel_vld_q;
    on_idx_d = on_idx_q;   act_idx_d = act_idx_q; fre_idx_d = fre_idx_q; rel_idx_d = rel_idx_q;
    steal_d = steal_q;
    pressed_d = 1'b0; released_d = 1'b0; keypress_d = 1'b0; pitch_d = 1'b0;
    miss_d = 1'b0;    stole_d = 1'b0;
    note_d = note_q;  vel_d = vel_q; ch_d = ch_q; addr_d = addr_q;
    we = 1'b0;
    wr_tag = '{busy: 1'b1, rel: 1'b0, ch: ev_ch_q, note: ev_note_q};
    inc = 1'b0;
    dec = free_valid && fr_busy;
    in_ready = (state_q == ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_op_eff == OP_PITCH) begin
            pitch_d = 1'b1;
            ch_d    = in_channel;
            note_d  = in_note;
          end else begin
            state_d   = ST_SCAN;
            scan_d    = '0;
            op_d      = in_op_eff;
            ev_ch_d   = in_channel;
            ev_note_d = in_note;
            ev_vel_d  = in_velocity;
            on_vld_d  = 1'b0; act_vld_d = 1'b0; fre_vld_d = 1'b0; rel_vld_d = 1'b0;
          end
        end
      end
      ST_SCAN: begin
        if (hit && !on_vld_d) begin
          on_vld_d = 1'b1; on_idx_d = scan_q;
        end
        if (hit && !rd_tag.rel && !act_vld_q) begin
          act_vld_d = 1'b1; act_idx_d = scan_q;
        end
        if (!rd_tag.busy && !fre_vld_q) begin
          fre_vld_d = 1'b1; fre_idx_d = scan_q;
        end
        if (rd_tag.busy && rd_tag.rel && !rel_vld_q) begin
          rel_vld_d = 1'b1; rel_idx_d = scan_q;
        end
        scan_d = scan_q + AW'(1);
        if (scan_q == AW'(NUM_VOICES - 1)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
        if (op_q == OP_NOTE_ON || act_ok) begin
          note_d = ev_note_q;
          vel_d  = ev_vel_q;
          ch_d   = ev_ch_q;
          addr_d = ADDR_OUT_W'(iss_slot);
        end
        unique case (op_q)
          OP_NOTE_ON: begin
            we        = 1'b1;
            pressed_d = 1'b1;
            stole_d   = iss_steal;
            inc       = !rd_tag.busy || free_hit;
            if (iss_steal) steal_d = steal_q + AW'(1);
          end
          OP_NOTE_OFF: begin
            we         = act_ok;
            wr_tag.rel = 1'b1;
            released_d = act_ok;
            miss_d     = !act_ok;
          end
          default: begin
            keypress_d = act_ok;
            miss_d     = !act_ok;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    busy_cnt_d = busy_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end

  always_ff @(posedge clk96 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;  scan_q <= '0;  op_q <= OP_NOTE_ON;
      ev_ch_q <= '0;       ev_note_q <= '0; ev_vel_q <= '0;
      on_vld_q <= 1'b0;    act_vld_q <= 1'b0; fre_vld_q <= 1'b0; rel_vld_q <= 1'b0;
      on_idx_q <= '0;      act_idx_q <= '0;   fre_idx_q <= '0;   rel_idx_q <= '0;
      steal_q <= '0;       busy_cnt_q <= '0;
      pressed_q <= 1'b0;   released_q <= 1'b0; keypress_q <= 1'b0; pitch_q <= 1'b0;
      miss_q <= 1'b0;      stole_q <= 1'b0;
      note_q <= '0;        vel_q <= '0; ch_q <= '0; addr_q <= '0;
    end else begin
      state_q <= state_d;  scan_q <= scan_d;  op_q <= op_d;
      ev_ch_q <= ev_ch_d;  ev_note_q <= ev_note_d; ev_vel_q <= ev_vel_d;
      on_vld_q <= on_vld_d; act_vld_q <= act_vld_d; fre_vld_q <= fre_vld_d; rel_vld_q <= rel_vld_d;
      on_idx_q <= on_idx_d; act_idx_q <= act_idx_d; fre_idx_q <= fre_idx_d; rel_idx_q <= rel_idx_d;
      steal_q <= steal_d;  busy_cnt_q <= busy_cnt_d;
      pressed_q <= pressed_d; released_q <= released_d; keypress_q <= keypress_d; pitch_q <= pitch_d;
      miss_q <= miss_d;    stole_q <= stole_d;
      note_q <= note_d;    vel_q <= vel_d; ch_q <= ch_d; addr_q <= addr_d;
    end
  end

  assign note_pressed  = pressed_q;
  assign note_released = released_q;
  assign note_keypress = keypress_q;
  assign pitch_wheel   = pitch_q;
  assign note          = note_q;
  assign velocity      = vel_q;
  assign channel       = ch_q;
  assign addr          = addr_q;
  assign busy_count    = busy_cnt_q;
  assign miss          = miss_q;
  assign stole         = stole_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: a 4-voice instance for allocation behaviour and a
// 256-voice instance for full-size latency.
module tb_voice_alloc;
  import voice_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_ready;
  logic [1:0] in_op = '0;
  logic [3:0] in_channel = '0;
  logic [6:0] in_note = '0, in_velocity = '0;
  logic       free_valid = 1'b0;
  logic [1:0] free_addr = '0;
  logic       np, nr, nk, pw, miss, stole;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr;
  logic [2:0] busy_count;

  voice_alloc #(.NUM_VOICES(4), .AW(2)) dut (
    .clk96(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_channel(in_channel), .in_note(in_note), .in_velocity(in_velocity),
    .free_valid(free_valid), .free_addr(free_addr),
    .note_pressed(np), .note_released(nr), .note_keypress(nk), .pitch_wheel(pw),
    .note(note), .velocity(velocity), .channel(channel), .addr(addr),
    .busy_count(busy_count), .miss(miss), .stole(stole)
  );

  logic       b_valid = 1'b0, b_ready;
  logic [1:0] b_op = '0;
  logic [3:0] b_channel = '0;
  logic [6:0] b_note = '0, b_velocity = '0;
  logic       b_free_valid = 1'b0;
  logic [7:0] b_free_addr = '0;
  logic       b_np, b_nr, b_nk, b_pw, b_miss, b_stole;
  logic [6:0] b_note_o, b_velocity_o;
  logic [3:0] b_channel_o;
  logic [7:0] b_addr;
  logic [8:0] b_busy_count;

  voice_alloc #(.NUM_VOICES(256), .AW(8)) dut256 (
    .clk96(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_op(b_op),
    .in_channel(b_channel), .in_note(b_note), .in_velocity(b_velocity),
    .free_valid(b_free_valid), .free_addr(b_free_addr),
    .note_pressed(b_np), .note_released(b_nr), .note_keypress(b_nk), .pitch_wheel(b_pw),
    .note(b_note_o), .velocity(b_velocity_o), .channel(b_channel_o), .addr(b_addr),
    .busy_count(b_busy_count), .miss(b_miss), .stole(b_stole)
  );

  int total = 0;
  int bad = 0;

  int g_lat;
  logic g_np, g_nr, g_nk, g_pw, g_miss, g_stole, g_rdy_mid;
  logic [7:0] g_addr;
  logic [6:0] g_note, g_vel;
  logic [3:0] g_ch;
  logic [2:0] g_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one event on the 4-voice DUT and captures the first response cycle.
  // fat>0 drives free_valid/free_addr=fa during response cycle number fat.
  task automatic evt(input logic [1:0] op, input logic [3:0] ch, input logic [6:0] nt,
                     input logic [6:0] vel, input int fat, input logic [1:0] fa);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_channel = ch; in_note = nt; in_velocity = vel;
    @(posedge clk);
    #1 in_valid = 1'b0;
    g_lat = 0;
    g_rdy_mid = 1'bx;
    while (g_lat < 20) begin
      @(negedge clk);
      g_lat++;
      if (g_lat == fat) begin
        free_valid = 1'b1; free_addr = fa;
      end else begin
        free_valid = 1'b0;
      end
      if (g_lat == 2) g_rdy_mid = in_ready;
      if (np || nr || nk || pw || miss) break;
    end
    free_valid = 1'b0;
    g_np = np; g_nr = nr; g_nk = nk; g_pw = pw; g_miss = miss; g_stole = stole;
    g_addr = addr; g_note = note; g_vel = velocity; g_ch = channel; g_busy = busy_count;
  endtask

  task automatic do_free(input logic [1:0] a);
    @(negedge clk);
    free_valid = 1'b1; free_addr = a;
    @(negedge clk);
    free_valid = 1'b0;
  endtask

  initial begin
    int lat256;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_pulses", {np, nr, nk, pw, miss, stole}, 0);
    chk("rst_fields", {note, velocity, channel, addr}, 0);
    chk("rst_busy", busy_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two NOTE_ONs land in successive free slots.
    evt(OP_NOTE_ON, 4'd0, 7'd60, 7'd100, 0, 2'd0);
    chk("on1_lat", g_lat, 6);
    chk("on1_pulse", {g_np, g_nr, g_nk, g_pw, g_miss, g_stole}, 6'b100000);
    chk("on1_addr", g_addr, 0);
    chk("on1_fields", {g_note, g_vel, g_ch}, {7'd60, 7'd100, 4'd0});
    chk("on1_ready_mid", g_rdy_mid, 0);
    evt(OP_NOTE_ON, 4'd1, 7'd62, 7'd90, 0, 2'd0);
    chk("on2_lat", g_lat, 6);
    chk("on2_addr", g_addr, 1);
    chk("on2_busy", g_busy, 2);

    // Reset in the middle of a scan.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_NOTE_ON; in_channel = 4'd3; in_note = 7'd50; in_velocity = 7'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_fields", {note, velocity, channel, addr}, 0);
    chk("mid_rst_busy", busy_count, 0);
    @(negedge clk);
    rst = 1'b0;
    evt(OP_NOTE_ON, 4'd1, 7'd62, 7'd90, 0, 2'd0);
    chk("post_rst_addr", g_addr, 0);
    chk("post_rst_busy", g_busy, 1);

    // Fill, then steal round-robin.
    evt(OP_NOTE_ON, 4'd0, 7'd64, 7'd10, 0, 2'd0);
    evt(OP_NOTE_ON, 4'd0, 7'd65, 7'd10, 0, 2'd0);
    evt(OP_NOTE_ON, 4'd0, 7'd66, 7'd10, 0, 2'd0);
    chk("fill_addr", g_addr, 3);
    chk("fill_busy", g_busy, 4);
    evt(OP_NOTE_ON, 4'd0, 7'd67, 7'd11, 0, 2'd0);
    chk("steal1", {g_np, g_stole, g_addr}, {1'b1, 1'b1, 8'd0});
    chk("steal1_busy", g_busy, 4);
    evt(OP_NOTE_ON, 4'd0, 7'd68, 7'd12, 0, 2'd0);
    chk("steal2", {g_np, g_stole, g_addr}, {1'b1, 1'b1, 8'd1});
    chk("steal2_busy", g_busy, 4);
    evt(OP_NOTE_ON, 4'd0, 7'd65, 7'd13, 0, 2'd0);
    chk("retrig", {g_np, g_stole, g_addr, g_busy}, {1'b1, 1'b0, 8'd2, 3'd4});

    // Note off, repeat off (miss), velocity-0 note on.
    evt(OP_NOTE_OFF, 4'd0, 7'd67, 7'd0, 0, 2'd0);
    chk("off", {g_np, g_nr, g_miss, g_addr}, {1'b0, 1'b1, 1'b0, 8'd0});
    chk("off_lat", g_lat, 6);
    evt(OP_NOTE_OFF, 4'd0, 7'd67, 7'd0, 0, 2'd0);
    chk("off_miss", {g_np, g_nr, g_nk, g_miss}, 4'b0001);
    chk("off_miss_addr", g_addr, 0);
    evt(OP_NOTE_ON, 4'd0, 7'd68, 7'd0, 0, 2'd0);
    chk("vel0_off", {g_np, g_nr, g_miss, g_addr}, {1'b0, 1'b1, 1'b0, 8'd1});

    // Free the released voices, refill them.
    do_free(2'd0);
    do_free(2'd1);
    chk("freed_busy", busy_count, 2);
    evt(OP_NOTE_ON, 4'd0, 7'd70, 7'd20, 0, 2'd0);
    chk("refill0", {g_stole, g_addr, g_busy}, {1'b0, 8'd0, 3'd3});
    evt(OP_NOTE_ON, 4'd0, 7'd71, 7'd21, 0, 2'd0);
    chk("refill1", {g_stole, g_addr, g_busy}, {1'b0, 8'd1, 3'd4});

    // Releasing voice is preferred over steal; a free on the issue cycle loses to the note on.
    evt(OP_NOTE_OFF, 4'd0, 7'd65, 7'd0, 0, 2'd0);
    chk("rel2", {g_nr, g_addr}, {1'b1, 8'd2});
    evt(OP_NOTE_ON, 4'd2, 7'd80, 7'd30, 5, 2'd2);
    chk("relpick", {g_np, g_stole, g_addr}, {1'b1, 1'b0, 8'd2});
    chk("relpick_busy", g_busy, 4);
    evt(OP_NOTE_OFF, 4'd2, 7'd80, 7'd0, 0, 2'd0);
    chk("slot2_still_busy", {g_nr, g_miss, g_addr}, {1'b1, 1'b0, 8'd2});

    // Pitch wheel bypasses the scan and leaves addr alone.
    evt(OP_PITCH, 4'd3, 7'h40, 7'd0, 0, 2'd0);
    chk("pitch_lat", g_lat, 1);
    chk("pitch", {g_pw, g_np, g_ch, g_note, g_addr}, {1'b1, 1'b0, 4'd3, 7'h40, 8'd2});
    evt(OP_KEYPRESS, 4'd0, 7'd70, 7'd33, 0, 2'd0);
    chk("keypress", {g_nk, g_miss, g_addr, g_vel, g_busy}, {1'b1, 1'b0, 8'd0, 7'd33, 3'd4});
    evt(OP_KEYPRESS, 4'd5, 7'd1, 7'd9, 0, 2'd0);
    chk("keypress_miss", {g_nk, g_miss, g_addr}, {1'b0, 1'b1, 8'd0});

    // Free of a non-busy slot has no effect.
    do_free(2'd2);
    chk("free_busy", busy_count, 3);
    do_free(2'd2);
    chk("free_nonbusy", busy_count, 3);

    // Full-size latency.
    @(negedge clk);
    b_valid = 1'b1; b_op = OP_NOTE_ON; b_channel = 4'd0; b_note = 7'd10; b_velocity = 7'd5;
    @(posedge clk);
    #1 b_valid = 1'b0;
    lat256 = 0;
    while (lat256 < 400) begin
      @(negedge clk);
      lat256++;
      if (b_np) break;
    end
    chk("lat256", lat256, 258);
    chk("lat256_addr", {b_np, b_addr, b_busy_count}, {1'b1, 8'd0, 9'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
